// File: rtl/exe_pipe_adder.sv
// Pipelined add/subtract unit for the EXE stage: WIDTH bits in STAGES carry-registered segments.
// Optional saturation: define EXE_PIPE_ADDER_SAT_EN to add the `sat` input and clamp on overflow.
module exe_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             sub,
  input  logic             signed_op,
`ifdef EXE_PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  // One pipeline slot: full operands travel along so later segments can take their slices.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             sgn;
    logic             sat;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t           stage_q [STAGES];
  stage_t           stage_d [STAGES];
  stage_t           in_stage;
  stage_t           src;
  stage_t           last;
  logic [SEG:0]     seg_sum;
  logic [WIDTH-1:0] final_sum;
  logic             cin_msb;
  logic             ovf;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             advance;
  logic             sat_in;

`ifdef EXE_PIPE_ADDER_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign advance  = ~stage_q[STAGES-1].valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    in_stage       = '0;
    in_stage.valid = in_valid;
    in_stage.sub   = sub;
    in_stage.sgn   = signed_op;
    in_stage.sat   = sat_in;
    in_stage.carry = sub;
    in_stage.a     = add_in1;
    in_stage.b     = sub ? ~add_in2 : add_in2;
  end

  // NOTE: every variable in this block gets a default before any conditional use, so no latches form.
  always_comb begin
    seg_sum   = '0;
    src       = in_stage;
    final_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = '0;
    end

    // Segment k consumes its slice and the carry left by segment k-1.
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.b[k*SEG +: SEG]}
              + {{SEG{1'b0}}, src.carry};
      stage_d[k]                   = src;
      stage_d[k].sum[k*SEG +: SEG] = seg_sum[SEG-1:0];
      stage_d[k].carry             = seg_sum[SEG];
      src                          = stage_q[k];
    end

    last    = stage_d[STAGES-1];
    cin_msb = last.sum[WIDTH-1] ^ last.a[WIDTH-1] ^ last.b[WIDTH-1];
    // Unsigned subtraction overflows on borrow, i.e. when the raw carry is 0.
    ovf     = last.sgn ? (cin_msb ^ last.carry) : (last.carry ^ last.sub);

    final_sum = last.sum;
    if (last.sat && ovf) begin
      if (last.sgn) begin
        final_sum = last.sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        final_sum = last.sub ? '0 : '1;
      end
    end

    stage_d[STAGES-1].sum = final_sum;
    overflow_d            = ovf;
    zero_d                = (final_sum == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (flush) begin
      // Kill in-flight ops only; the last presented result and flags stay put.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k].valid <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k].valid <= stage_d[k].valid;
        if (stage_d[k].valid) begin
          stage_q[k] <= stage_d[k];
        end
      end
      if (stage_d[STAGES-1].valid) begin
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign add_out   = stage_q[STAGES-1].sum;
  assign carry_out = stage_q[STAGES-1].carry;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_exe_pipe_adder.sv
// Directed self-checking bench for exe_pipe_adder (WIDTH=32, STAGES=2).
module tb_exe_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] add_in1 = '0;
  logic [WIDTH-1:0] add_in2 = '0;
  logic             sub = 1'b0;
  logic             signed_op = 1'b0;
  logic             sat = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] add_out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int n_checks = 0;
  int n_pass   = 0;

  exe_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .sub       (sub),
    .signed_op (signed_op),
`ifdef EXE_PIPE_ADDER_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add_out   (add_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic sg);
    in_valid  = v;
    add_in1   = a;
    add_in2   = b;
    sub       = s;
    signed_op = sg;
  endtask

  // Issue one op, then bubbles until it reaches the output.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic sg);
    drive(1'b1, a, b, s, sg);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (STAGES - 1) tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_add_out", add_out, 32'd0);
    check("rst_carry", {31'b0, carry_out}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Back-to-back unsigned adds
    drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("b2b_latency_not_yet", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 32'd15, 32'd25, 1'b0, 1'b0);
    tick();
    check("b2b_v0", {31'b0, out_valid}, 32'd1);
    check("b2b_r0", add_out, 32'd30);
    check("b2b_c0", {31'b0, carry_out}, 32'd0);
    check("b2b_o0", {31'b0, overflow}, 32'd0);
    drive(1'b1, 32'd4, 32'd2, 1'b0, 1'b0);
    tick();
    check("b2b_r1", add_out, 32'd40);
    drive(1'b1, 32'd41, 32'd26, 1'b0, 1'b0);
    tick();
    check("b2b_r2", add_out, 32'd6);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    check("b2b_v3", {31'b0, out_valid}, 32'd1);
    check("b2b_r3", add_out, 32'd67);
    tick();
    check("b2b_drained", {31'b0, out_valid}, 32'd0);

    // Unsigned add wrap
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("uadd_valid", {31'b0, out_valid}, 32'd1);
    check("uadd_sum", add_out, 32'd0);
    check("uadd_carry", {31'b0, carry_out}, 32'd1);
    check("uadd_ovf", {31'b0, overflow}, 32'd1);
    check("uadd_zero", {31'b0, zero}, 32'd1);

    // Signed sub overflow
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    check("ssub_sum", add_out, 32'h7FFF_FFFF);
    check("ssub_ovf", {31'b0, overflow}, 32'd1);
    check("ssub_carry", {31'b0, carry_out}, 32'd1);
    check("ssub_zero", {31'b0, zero}, 32'd0);

    // Unsigned sub borrow
    run_op(32'd5, 32'd7, 1'b1, 1'b0);
    check("usub_sum", add_out, 32'hFFFF_FFFE);
    check("usub_carry", {31'b0, carry_out}, 32'd0);
    check("usub_ovf", {31'b0, overflow}, 32'd1);

    // Signed -1 + 1: carry out but no signed overflow
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    check("sadd_sum", add_out, 32'd0);
    check("sadd_carry", {31'b0, carry_out}, 32'd1);
    check("sadd_ovf", {31'b0, overflow}, 32'd0);
    check("sadd_zero", {31'b0, zero}, 32'd1);

    // Signed positive overflow (wraps unless saturating)
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    check("spos_sum", add_out, 32'h8000_0000);
    check("spos_ovf", {31'b0, overflow}, 32'd1);
    check("spos_carry", {31'b0, carry_out}, 32'd0);

`ifdef EXE_PIPE_ADDER_SAT_EN
    sat = 1'b1;
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    check("sat_pos_sum", add_out, 32'h7FFF_FFFF);
    check("sat_pos_ovf", {31'b0, overflow}, 32'd1);
    run_op(32'd5, 32'd7, 1'b1, 1'b0);
    check("sat_usub_sum", add_out, 32'd0);
    check("sat_usub_zero", {31'b0, zero}, 32'd1);
    sat = 1'b0;
`endif

    // Backpressure with a full pipe
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold", add_out, 32'd2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("bp_drain1", add_out, 32'd4);
    tick();
    check("bp_drain2_valid", {31'b0, out_valid}, 32'd1);
    check("bp_drain2", add_out, 32'd6);
    tick();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush with two ops in flight plus an accept
    drive(1'b1, 32'd100, 32'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd200, 32'd2, 1'b0, 1'b0);
    tick();
    check("fl_pre_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 32'd300, 32'd3, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("fl_valid0", {31'b0, out_valid}, 32'd0);
    check("fl_hold_sum", add_out, 32'd101);
    tick();
    check("fl_valid1", {31'b0, out_valid}, 32'd0);

    // Async reset mid-stream
    drive(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd8, 32'd8, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_sum", add_out, 32'd0);
    check("ar_in_ready", {31'b0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    tick();
    check("ar_stale", {31'b0, out_valid}, 32'd0);
    run_op(32'd7, 32'd8, 1'b0, 1'b0);
    check("ar_recover_valid", {31'b0, out_valid}, 32'd1);
    check("ar_recover_sum", add_out, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
